// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the core
// load/store port (m0) and a secondary master (m1).
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CMAX = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    owner_t        owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          both, burst0, burst1;
    logic          g0, g1;

    assign both   = m0_req & m1_req;
    assign burst0 = (owner_q == OWN0) && (cnt_q != CMAX);
    assign burst1 = (owner_q == OWN1) && (cnt_q != CMAX);

    // Grants are suppressed while reset is low so nothing is written.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (reset) begin
            unique case (1'b1)
                both & burst0:           g0 = 1'b1;
                both & burst1:           g1 = 1'b1;
                both & ~burst0 & ~burst1: begin
                    g0 = last_q;
                    g1 = ~last_q;
                end
                m0_req & ~m1_req:        g0 = 1'b1;
                m1_req & ~m0_req:        g1 = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        owner_d = IDLE;
        cnt_d   = '0;
        last_d  = last_q;
        if (g0) begin
            owner_d = OWN0;
            last_d  = 1'b0;
            if (owner_q == OWN0)
                cnt_d = (cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);
        end else if (g1) begin
            owner_d = OWN1;
            last_d  = 1'b1;
            if (owner_q == OWN1)
                cnt_d = (cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);
        end
    end

    assign m0_gnt = g0;
    assign m1_gnt = g1;
    assign mem_we = (g0 & m0_we) | (g1 & m1_we);
    assign mem_a  = g0 ? m0_addr  : (g1 ? m1_addr  : '0);
    assign mem_wd = g0 ? m0_wdata : (g1 ? m1_wdata : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            m0_rvalid <= g0 & ~m0_we;
            m1_rvalid <= g1 & ~m1_we;
            if (g0 & ~m0_we)
                m0_rdata <= mem_rd;
            if (g1 & ~m1_we)
                m1_rdata <= mem_rd;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: burst-4 and burst-1 instances
// sharing stimulus, with a small behavioural dmem on the burst-4 one.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
    logic [31:0] m0_rdata, m1_rdata, mem_a, mem_wd, mem_rd;

    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_we;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_a, b_mem_wd;

    logic [31:0] mem [0:255];
    logic        clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) u0 (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(1)) u1 (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid),
        .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid),
        .m1_rdata(b_m1_rdata),
        .mem_we(b_mem_we), .mem_a(b_mem_a), .mem_wd(b_mem_wd),
        .mem_rd(32'hA5A5_0001)
    );

    assign mem_rd = mem[mem_a[9:2]];

    always @(posedge clk) begin
        if (clr) begin
            for (int k = 0; k < 256; k++) mem[k] <= '0;
        end else if (mem_we) begin
            mem[mem_a[9:2]] <= mem_wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int e4 [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int e1 [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        clr      = 1'b1;
        reset    = 1'b0;
        m0_req   = 1'b1;
        m1_req   = 1'b1;
        m0_we    = 1'b0;
        m1_we    = 1'b0;
        m0_addr  = 32'h0;
        m1_addr  = 32'h4;
        m0_wdata = 32'h0;
        m1_wdata = 32'h0;
        tick();
        clr = 1'b0;
        tick();

        // held in reset with both requesting
        check("rst_g0", {31'b0, m0_gnt}, 0);
        check("rst_g1", {31'b0, m1_gnt}, 0);
        check("rst_we", {31'b0, mem_we}, 0);
        check("rst_a", mem_a, 0);
        check("rst_rv0", {31'b0, m0_rvalid}, 0);
        check("rst_rv1", {31'b0, m1_rvalid}, 0);
        check("rst_rd0", m0_rdata, 0);
        check("rst_b_g0", {31'b0, b_m0_gnt}, 0);

        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("c4_g0", {31'b0, m0_gnt}, (e4[i] == 0) ? 1 : 0);
            check("c4_g1", {31'b0, m1_gnt}, (e4[i] == 1) ? 1 : 0);
            check("c4_rv0", {31'b0, m0_rvalid},
                  (i > 0 && e4[i-1] == 0) ? 1 : 0);
            check("c4_rv1", {31'b0, m1_rvalid},
                  (i > 0 && e4[i-1] == 1) ? 1 : 0);
            check("c1_g0", {31'b0, b_m0_gnt}, (e1[i] == 0) ? 1 : 0);
            check("c1_g1", {31'b0, b_m1_gnt}, (e1[i] == 1) ? 1 : 0);
            check("c_1hot", {31'b0, m0_gnt & m1_gnt}, 0);
            tick();
        end

        // one idle cycle, then a tie: u1 last=1 -> m0, u0 last=0 -> m1
        m0_req = 1'b0;
        m1_req = 1'b0;
        #1;
        check("idle_g0", {31'b0, m0_gnt}, 0);
        check("idle_g1", {31'b0, m1_gnt}, 0);
        check("idle_b_g1", {31'b0, b_m1_gnt}, 0);
        tick();
        m0_req = 1'b1;
        m1_req = 1'b1;
        #1;
        check("tie_b_g0", {31'b0, b_m0_gnt}, 1);
        check("tie_b_g1", {31'b0, b_m1_gnt}, 0);
        check("tie_g1", {31'b0, m1_gnt}, 1);
        check("tie_g0", {31'b0, m0_gnt}, 0);
        tick();
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        tick();

        // single master: write then read back
        m0_req   = 1'b1;
        m0_we    = 1'b1;
        m0_addr  = 32'h40;
        m0_wdata = 32'hDEADBEEF;
        #1;
        check("sw_g0", {31'b0, m0_gnt}, 1);
        check("sw_we", {31'b0, mem_we}, 1);
        check("sw_a", mem_a, 32'h40);
        check("sw_wd", mem_wd, 32'hDEADBEEF);
        check("sw_g1", {31'b0, m1_gnt}, 0);
        tick();
        m0_we = 1'b0;
        #1;
        check("sr_g0", {31'b0, m0_gnt}, 1);
        check("sr_we", {31'b0, mem_we}, 0);
        check("sr_rv0", {31'b0, m0_rvalid}, 0);
        tick();
        m0_req = 1'b0;
        #1;
        check("sr_rv0b", {31'b0, m0_rvalid}, 1);
        check("sr_rd0", m0_rdata, 32'hDEADBEEF);
        check("sr_we2", {31'b0, mem_we}, 0);
        check("sr_a0", mem_a, 0);
        check("sr_g1", {31'b0, m1_gnt}, 0);
        tick();
        #1;
        check("sr_rv0c", {31'b0, m0_rvalid}, 0);
        check("sr_hold", m0_rdata, 32'hDEADBEEF);
        tick();

        // isolation: m1 writes while m0 waits, then m0 reads it
        m0_req   = 1'b1;
        m0_we    = 1'b0;
        m0_addr  = 32'h80;
        m1_req   = 1'b1;
        m1_we    = 1'b1;
        m1_addr  = 32'h80;
        m1_wdata = 32'h12345678;
        #1;
        check("iso_g1", {31'b0, m1_gnt}, 1);
        check("iso_g0", {31'b0, m0_gnt}, 0);
        check("iso_we", {31'b0, mem_we}, 1);
        check("iso_wd", mem_wd, 32'h12345678);
        tick();
        m1_req = 1'b0;
        #1;
        check("iso_g0b", {31'b0, m0_gnt}, 1);
        check("iso_a", mem_a, 32'h80);
        check("iso_rv1", {31'b0, m1_rvalid}, 0);
        tick();
        m0_req = 1'b0;
        #1;
        check("iso_rv0", {31'b0, m0_rvalid}, 1);
        check("iso_rd0", m0_rdata, 32'h12345678);
        check("iso_rv1b", {31'b0, m1_rvalid}, 0);
        tick();

        // reset asserted during an m1 write grant
        m1_req   = 1'b1;
        m1_we    = 1'b1;
        m1_wdata = 32'hBAD0BAD0;
        #1;
        check("mr_g1", {31'b0, m1_gnt}, 1);
        #1;
        reset = 1'b0;
        #1;
        check("mr_g1r", {31'b0, m1_gnt}, 0);
        check("mr_we", {31'b0, mem_we}, 0);
        check("mr_rd0", m0_rdata, 0);
        tick();
        reset  = 1'b1;
        m1_we  = 1'b0;
        m0_req = 1'b1;
        #1;
        check("mr_tie0", {31'b0, m0_gnt}, 1);
        check("mr_tie1", {31'b0, m1_gnt}, 0);
        tick();
        m0_req = 1'b0;
        #1;
        check("mr_rv0", {31'b0, m0_rvalid}, 1);
        check("mr_old", m0_rdata, 32'h12345678);
        check("mr_g1b", {31'b0, m1_gnt}, 1);
        tick();
        m1_req = 1'b0;
        #1;
        check("mr_rv1", {31'b0, m1_rvalid}, 1);
        check("mr_old1", m1_rdata, 32'h12345678);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
